pio_edge_event_sequencer: RTL and testbench

Autonomous Avalon-MM master that services a 32-bit edge-capturing PIO slave (2-bit address, 1-cycle registered read latency). On PIO irq it reads the edge-capture register, clears it, samples the live input register and emits one {capture, data, time} event on a valid/ready stream toward the HPS/FIFO path. It programs the PIO irq mask at reset exit and on request, so the processor never touches the PIO registers directly.

---
 rtl/pio_edge_event_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_pio_edge_event_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_edge_event_sequencer.sv
// Avalon-MM master that services an edge-capturing PIO: on irq it reads and clears edge_capture, samples data, emits one event.
// Latency: irq sampled in IDLE at edge k -> evt_valid high after edge k+5; 7-cycle minimum event period with evt_ready high.
// Backpressure: OUT holds evt_* stable until evt_ready; new edges accumulate in the PIO capture register meanwhile.
// Optional timestamp counter: define PIO_SEQ_TIMESTAMP_EN (otherwise evt_time is constant 0).
module pio_edge_event_sequencer #(
  parameter logic [31:0] INIT_MASK = 32'hFFFF_FFFF,
  parameter int          TS_W      = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [31:0]     cfg_mask,
  input  logic            cfg_mask_wr,
  output logic [1:0]      pio_address,
  output logic            pio_chipselect,
  output logic            pio_write_n,
  output logic [31:0]     pio_writedata,
  input  logic [31:0]     pio_readdata,
  input  logic            pio_irq,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [31:0]     evt_capture,
  output logic [31:0]     evt_data,
  output logic [TS_W-1:0] evt_time,
  output logic            busy,
  output logic [15:0]     evt_count
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef enum logic [2:0] {
    S_WR_MASK,
    S_IDLE,
    S_RD_CAP,
    S_CAP_LAT,
    S_CLR_CAP,
    S_RD_DAT,
    S_DAT_LAT,
    S_OUT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mask_q, mask_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_val_q, pend_val_d;

  logic [1:0]  addr_q, addr_d;
  logic        cs_q, cs_d;
  logic        wn_q, wn_d;
  logic [31:0] wdata_q, wdata_d;

  logic        valid_q;
  logic [31:0] cap_q;
  logic [31:0] dat_q;
  logic [15:0] cnt_q;
  logic        busy_q;

  // Next-state logic, irq-mask bookkeeping and deferral of mask requests that arrive outside IDLE.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    unique case (state_q)
      // Leave only once the mask write is actually on the bus; out of reset
      // the bus is still idle, so the first cycle here launches the write.
      S_WR_MASK: if (cs_q) state_d = S_IDLE;
      S_IDLE: begin
        if (cfg_mask_wr || pend_q) begin
          // A fresh pulse supersedes an older pending value.
          mask_d  = cfg_mask_wr ? cfg_mask : pend_val_q;
          pend_d  = 1'b0;
          state_d = S_WR_MASK;
        end else if (en && pio_irq) begin
          state_d = S_RD_CAP;
        end
      end
      S_RD_CAP:  state_d = S_CAP_LAT;
      // Zero capture means the irq was spurious: no clear, no event.
      S_CAP_LAT: state_d = (pio_readdata == 32'd0) ? S_IDLE : S_CLR_CAP;
      S_CLR_CAP: state_d = S_RD_DAT;
      S_RD_DAT:  state_d = S_DAT_LAT;
      S_DAT_LAT: state_d = S_OUT;
      S_OUT:     if (evt_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (cfg_mask_wr && (state_q != S_IDLE)) begin
      pend_d     = 1'b1;
      pend_val_d = cfg_mask;
    end
  end

  // Bus access decode from the next state so each access is driven during its own state cycle.
  always_comb begin
    addr_d  = ADDR_DATA;
    cs_d    = 1'b0;
    wn_d    = 1'b1;
    wdata_d = 32'd0;
    unique case (state_d)
      S_WR_MASK: begin
        addr_d  = ADDR_MASK;
        cs_d    = 1'b1;
        wn_d    = 1'b0;
        wdata_d = mask_d;
      end
      S_RD_CAP: begin
        addr_d = ADDR_EDGE;
        cs_d   = 1'b1;
      end
      S_CLR_CAP: begin
        addr_d  = ADDR_EDGE;
        cs_d    = 1'b1;
        wn_d    = 1'b0;
        wdata_d = 32'hFFFF_FFFF;
      end
      S_RD_DAT: begin
        addr_d = ADDR_DATA;
        cs_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // Control state: FSM, irq mask and the pending mask request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_WR_MASK;
      mask_q     <= INIT_MASK;
      pend_q     <= 1'b0;
      pend_val_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
    end
  end

  // Registered Avalon-MM master outputs and busy flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= ADDR_DATA;
      cs_q    <= 1'b0;
      wn_q    <= 1'b1;
      wdata_q <= 32'd0;
      busy_q  <= 1'b1;
    end else begin
      addr_q  <= addr_d;
      cs_q    <= cs_d;
      wn_q    <= wn_d;
      wdata_q <= wdata_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  // Event payload capture, valid flag and accepted-event counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      cap_q   <= 32'd0;
      dat_q   <= 32'd0;
      cnt_q   <= 16'd0;
    end else begin
      valid_q <= (state_d == S_OUT);
      if (state_q == S_CAP_LAT) cap_q <= pio_readdata;
      if (state_q == S_DAT_LAT) dat_q <= pio_readdata;
      if (valid_q && evt_ready) cnt_q <= cnt_q + 16'd1;
    end
  end

`ifdef PIO_SEQ_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt_q;
  logic [TS_W-1:0] ts_q;
  logic            ts_take;

  assign ts_take = (state_q == S_IDLE) && (state_d == S_RD_CAP);

  // Free-running timestamp, snapshotted when an irq is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + TS_W'(1);
      if (ts_take) ts_q <= ts_cnt_q;
    end
  end

  assign evt_time = ts_q;
`else
  assign evt_time = '0;
`endif

  assign pio_address    = addr_q;
  assign pio_chipselect = cs_q;
  assign pio_write_n    = wn_q;
  assign pio_writedata  = wdata_q;
  assign evt_valid      = valid_q;
  assign evt_capture    = cap_q;
  assign evt_data       = dat_q;
  assign busy           = busy_q;
  assign evt_count      = cnt_q;

endmodule

// File: tb/tb_pio_edge_event_sequencer.sv
// Bench for pio_edge_event_sequencer with a behavioural edge-capturing PIO slave.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
// Table-driven bus/event vectors plus hand-written multi-cycle corner sequences.
module tb_pio_edge_event_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [31:0] cfg_mask;
  logic        cfg_mask_wr;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata;
  logic        pio_irq;
  logic        evt_valid;
  logic        evt_ready;
  logic [31:0] evt_capture;
  logic [31:0] evt_data;
  logic [31:0] evt_time;
  logic        busy;
  logic [15:0] evt_count;

  int n_cmp;
  int n_bad;
  int exp_cnt;

  always #5 clk = ~clk;

  pio_edge_event_sequencer #(.INIT_MASK(32'hFFFF_FFFF), .TS_W(32)) dut (
    .clk(clk), .reset(reset), .en(en), .cfg_mask(cfg_mask), .cfg_mask_wr(cfg_mask_wr),
    .pio_address(pio_address), .pio_chipselect(pio_chipselect), .pio_write_n(pio_write_n),
    .pio_writedata(pio_writedata), .pio_readdata(pio_readdata), .pio_irq(pio_irq),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_capture(evt_capture),
    .evt_data(evt_data), .evt_time(evt_time), .busy(busy), .evt_count(evt_count)
  );

  // Behavioural PIO slave: registered reads, write-1-to-clear edge capture, irq = |(cap & mask).
  logic [31:0] m_cap, m_mask, m_data, inj;
  logic        force_irq;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cap        <= 32'd0;
      m_mask       <= 32'd0;
      pio_readdata <= 32'd0;
    end else begin
      pio_readdata <= 32'd0;
      if (pio_chipselect && pio_write_n) begin
        case (pio_address)
          2'd0:    pio_readdata <= m_data;
          2'd2:    pio_readdata <= m_mask;
          2'd3:    pio_readdata <= m_cap;
          default: pio_readdata <= 32'd0;
        endcase
      end
      if (pio_chipselect && !pio_write_n && pio_address == 2'd2) m_mask <= pio_writedata;
      if (pio_chipselect && !pio_write_n && pio_address == 2'd3)
        m_cap <= (m_cap & ~pio_writedata) | inj;
      else
        m_cap <= m_cap | inj;
    end
  end

  assign pio_irq = force_irq | (|(m_cap & m_mask));

`ifdef PIO_SEQ_TIMESTAMP_EN
  logic [31:0] cyc;
  logic [31:0] t_irq;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 32'd0;
    else       cyc <= cyc + 32'd1;
  end
`endif

  typedef struct {
    logic        cs;
    logic        wn;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        vld;
  } bus_vec_t;

  typedef struct {
    logic [31:0] inj;
    logic [31:0] data;
    logic [31:0] exp_cap;
    logic [31:0] exp_dat;
  } evt_vec_t;

  bus_vec_t bus_tbl[6];
  evt_vec_t ev_tbl[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_bus(input string name, input logic cs, input logic wn,
                           input logic [1:0] addr);
    check(name, 32'({pio_chipselect, pio_write_n, pio_address}), 32'({cs, wn, addr}));
  endtask

  // Wait on falling edges for evt_valid, bounded by budget cycles.
  task automatic wait_valid(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (evt_valid) ok = 1'b1;
    end
  endtask

  // Pulse new edges into the PIO capture register for one clock.
  task automatic inject(input logic [31:0] bits);
    inj = bits;
    @(negedge clk);
    inj = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic ok;
    logic stable;
    logic saw_clr;
    logic saw_v;

    // Expected bus activity for one event, one entry per cycle after the irq is accepted.
    bus_tbl[0] = '{1'b1, 1'b1, 2'd3, 32'h0000_0000, 1'b0};  // read edge_capture
    bus_tbl[1] = '{1'b0, 1'b1, 2'd0, 32'h0000_0000, 1'b0};  // capture latency
    bus_tbl[2] = '{1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF, 1'b0};  // clear edge_capture
    bus_tbl[3] = '{1'b1, 1'b1, 2'd0, 32'h0000_0000, 1'b0};  // read data
    bus_tbl[4] = '{1'b0, 1'b1, 2'd0, 32'h0000_0000, 1'b0};  // data latency
    bus_tbl[5] = '{1'b0, 1'b1, 2'd0, 32'h0000_0000, 1'b1};  // event presented

    ev_tbl[0] = '{32'h8000_0001, 32'hA5A5_0000, 32'h8000_0001, 32'hA5A5_0000};
    ev_tbl[1] = '{32'h00FF_0000, 32'h0000_0000, 32'h00FF_0000, 32'h0000_0000};
    ev_tbl[2] = '{32'h0000_0010, 32'hFFFF_FFFF, 32'h0000_0010, 32'hFFFF_FFFF};

    n_cmp = 0; n_bad = 0; exp_cnt = 0;
    reset = 1'b1; en = 1'b1; cfg_mask = 32'd0; cfg_mask_wr = 1'b0; evt_ready = 1'b1;
    m_data = 32'd0; inj = 32'd0; force_irq = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check_bus("rst_bus", 1'b0, 1'b1, 2'd0);
    check("rst_wdata", pio_writedata, 32'd0);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_count", 32'(evt_count), 32'd0);
    check("rst_capture", evt_capture, 32'd0);
    check("rst_data", evt_data, 32'd0);
    check("rst_time", evt_time, 32'd0);

    // Release: exactly one mask write with INIT_MASK, then idle bus
    reset = 1'b0;
    @(negedge clk);
    check_bus("init_wr_bus", 1'b1, 1'b0, 2'd2);
    check("init_wr_data", pio_writedata, 32'hFFFF_FFFF);
    @(negedge clk);
    check_bus("init_idle_bus", 1'b0, 1'b1, 2'd0);
    check("init_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check_bus("init_no_rewrite", 1'b0, 1'b1, 2'd0);

    // First event, cycle by cycle: irq accepted at edge k, evt_valid after edge k+5
    m_data = 32'h1234_5678;
    inject(32'h0000_0005);
`ifdef PIO_SEQ_TIMESTAMP_EN
    t_irq = cyc;
`endif
    check("ev1_busy_before", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_bus($sformatf("ev1_bus[%0d]", i), bus_tbl[i].cs, bus_tbl[i].wn, bus_tbl[i].addr);
      check($sformatf("ev1_wdata[%0d]", i), pio_writedata, bus_tbl[i].wdata);
      check($sformatf("ev1_valid[%0d]", i), 32'(evt_valid), 32'(bus_tbl[i].vld));
    end
    check("ev1_capture", evt_capture, 32'h0000_0005);
    check("ev1_data", evt_data, 32'h1234_5678);
`ifdef PIO_SEQ_TIMESTAMP_EN
    check("ev1_time", evt_time, t_irq);
`else
    check("ev1_time", evt_time, 32'd0);
`endif
    @(negedge clk);
    exp_cnt++;
    check("ev1_valid_drop", 32'(evt_valid), 32'd0);
    check("ev1_count", 32'(evt_count), 32'(exp_cnt));
    check("ev1_busy_after", 32'(busy), 32'd0);

    // Event vectors with evt_ready held high
    for (int i = 0; i < 3; i++) begin
      m_data = ev_tbl[i].data;
      inject(ev_tbl[i].inj);
      wait_valid(20, ok);
      check($sformatf("tbl[%0d]_valid_seen", i), 32'(ok), 32'd1);
      check($sformatf("tbl[%0d]_capture", i), evt_capture, ev_tbl[i].exp_cap);
      check($sformatf("tbl[%0d]_data", i), evt_data, ev_tbl[i].exp_dat);
      @(negedge clk);
      exp_cnt++;
      check($sformatf("tbl[%0d]_count", i), 32'(evt_count), 32'(exp_cnt));
      check($sformatf("tbl[%0d]_valid_drop", i), 32'(evt_valid), 32'd0);
    end

    // Backpressure: 20-cycle stall, edge bit 8 and a mask request arrive during OUT
    evt_ready = 1'b0;
    m_data = 32'hCAFE_0001;
    inject(32'h0000_0001);
    wait_valid(20, ok);
    check("bp_valid_seen", 32'(ok), 32'd1);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 4)  inj = 32'h0000_0100;
      if (i == 5)  inj = 32'd0;
      if (i == 10) begin cfg_mask = 32'h0000_FFFF; cfg_mask_wr = 1'b1; end
      if (i == 11) cfg_mask_wr = 1'b0;
      @(negedge clk);
      if (!evt_valid || evt_capture !== 32'h1 || evt_data !== 32'hCAFE_0001 ||
          evt_count !== 16'(exp_cnt)) stable = 1'b0;
    end
    check("bp_stable", 32'(stable), 32'd1);
    check("bp_busy", 32'(busy), 32'd1);
    evt_ready = 1'b1;
    m_data = 32'h0BAD_F00D;
    @(negedge clk);
    exp_cnt++;
    check("bp_count", 32'(evt_count), 32'(exp_cnt));
    @(negedge clk);
    check_bus("bp_pending_mask_bus", 1'b1, 1'b0, 2'd2);
    check("bp_pending_mask_data", pio_writedata, 32'h0000_FFFF);
    wait_valid(20, ok);
    check("bp_next_valid_seen", 32'(ok), 32'd1);
    check("bp_next_capture", evt_capture, 32'h0000_0100);
    check("bp_next_data", evt_data, 32'h0BAD_F00D);
    @(negedge clk);
    exp_cnt++;
    check("bp_next_count", 32'(evt_count), 32'(exp_cnt));

    // cfg_mask_wr and irq in the same IDLE cycle: mask write first, irq still serviced
    m_data = 32'h5555_AAAA;
    inject(32'h0000_0002);
    cfg_mask = 32'h0000_000F; cfg_mask_wr = 1'b1;
    @(negedge clk);
    cfg_mask_wr = 1'b0;
    check_bus("cfg_wr_bus", 1'b1, 1'b0, 2'd2);
    check("cfg_wr_data", pio_writedata, 32'h0000_000F);
    @(negedge clk);
    check_bus("cfg_gap_bus", 1'b0, 1'b1, 2'd0);
    @(negedge clk);
    check_bus("cfg_rdcap_bus", 1'b1, 1'b1, 2'd3);
    wait_valid(20, ok);
    check("cfg_valid_seen", 32'(ok), 32'd1);
    check("cfg_capture", evt_capture, 32'h0000_0002);
    check("cfg_data", evt_data, 32'h5555_AAAA);
    @(negedge clk);
    exp_cnt++;
    check("cfg_count", 32'(evt_count), 32'(exp_cnt));

    // Spurious irq: capture reads 0 -> no clear, no event, back to IDLE
    force_irq = 1'b1;
    @(negedge clk);
    force_irq = 1'b0;
    check_bus("glitch_rdcap_bus", 1'b1, 1'b1, 2'd3);
    saw_clr = 1'b0;
    saw_v = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pio_chipselect && !pio_write_n && pio_address == 2'd3) saw_clr = 1'b1;
      if (evt_valid) saw_v = 1'b1;
    end
    check("glitch_no_clear", 32'(saw_clr), 32'd0);
    check("glitch_no_valid", 32'(saw_v), 32'd0);
    check("glitch_busy", 32'(busy), 32'd0);
    check("glitch_count", 32'(evt_count), 32'(exp_cnt));

    // Asynchronous reset while an event is held in OUT
    evt_ready = 1'b0;
    m_data = 32'h7777_0000;
    inject(32'h0000_0001);
    wait_valid(20, ok);
    check("rst_out_valid_seen", 32'(ok), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_out_valid", 32'(evt_valid), 32'd0);
    check_bus("rst_out_bus", 1'b0, 1'b1, 2'd0);
    check("rst_out_busy", 32'(busy), 32'd1);
    check("rst_out_count", 32'(evt_count), 32'd0);
    check("rst_out_capture", evt_capture, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    evt_ready = 1'b1;
    @(negedge clk);
    check_bus("rst_out_rewrite_bus", 1'b1, 1'b0, 2'd2);
    check("rst_out_rewrite_data", pio_writedata, 32'hFFFF_FFFF);
    @(negedge clk);
    check("rst_out_idle_busy", 32'(busy), 32'd0);
    check("rst_out_idle_valid", 32'(evt_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
